// File: rtl/maxnet_controller.sv
// Sequencing controller for a four-neuron MAXNET winner-take-all search.
// Drives the neuron load registers through init and inhibition-update rounds
// and reports the single surviving positive neuron, or a timeout.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for start; results from the last search held
//   INIT    | load external initial activations into neuron registers
//   CHECK   | count positive activations, decide finish or iterate
//   ITER    | load inhibition-update results, bump iteration counter
//   DONE    | one-cycle completion pulse
module maxnet_controller #(
  parameter int unsigned MAX_ITER = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value_0,
  input  logic [31:0] value_1,
  input  logic [31:0] value_2,
  input  logic [31:0] value_3,
  output logic        load,
  output logic        sel_init,
  output logic        busy,
  output logic        done,
  output logic        winner_valid,
  output logic [1:0]  winner_idx,
  output logic        timeout,
  output logic [7:0]  iter_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

  logic [2:0] state_q, state_d;
  logic [7:0] iter_q, iter_d;
  logic       winner_valid_q, winner_valid_d;
  logic [1:0] winner_idx_q, winner_idx_d;
  logic       timeout_q, timeout_d;

  logic [3:0] pos;
  logic [2:0] pos_cnt;
  logic [1:0] pos_idx;

  // Positive means sign clear and nonzero; zero and negatives are inactive.
  always_comb begin
    pos[0]  = ~value_0[31] & (|value_0);
    pos[1]  = ~value_1[31] & (|value_1);
    pos[2]  = ~value_2[31] & (|value_2);
    pos[3]  = ~value_3[31] & (|value_3);
    pos_cnt = {2'b00, pos[0]} + {2'b00, pos[1]} + {2'b00, pos[2]} + {2'b00, pos[3]};
    // Only meaningful when exactly one bit of pos is set.
    pos_idx = {pos[3] | pos[2], pos[3] | pos[1]};
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d        = state_q;
    iter_d         = iter_q;
    winner_valid_d = winner_valid_q;
    winner_idx_d   = winner_idx_q;
    timeout_d      = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_INIT;
          iter_d         = 8'd0;
          winner_valid_d = 1'b0;
          winner_idx_d   = 2'd0;
          timeout_d      = 1'b0;
        end
      end
      S_INIT: state_d = S_CHECK;
      S_CHECK: begin
        if (pos_cnt == 3'd1) begin
          state_d        = S_DONE;
          winner_valid_d = 1'b1;
          winner_idx_d   = pos_idx;
        end else if (pos_cnt == 3'd0) begin
          state_d        = S_DONE;
          winner_valid_d = 1'b0;
          winner_idx_d   = 2'd0;
          timeout_d      = 1'b0;
        end else if (iter_q == MAX_ITER_C) begin
          state_d        = S_DONE;
          winner_valid_d = 1'b0;
          winner_idx_d   = 2'd0;
          timeout_d      = 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        state_d = S_CHECK;
        // ITER is only reachable below the limit; the guard just keeps the
        // counter from ever wrapping.
        if (iter_q != MAX_ITER_C) iter_d = iter_q + 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      iter_q         <= 8'd0;
      winner_valid_q <= 1'b0;
      winner_idx_q   <= 2'd0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_q         <= iter_d;
      winner_valid_q <= winner_valid_d;
      winner_idx_q   <= winner_idx_d;
      timeout_q      <= timeout_d;
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    load     = (state_q == S_INIT) || (state_q == S_ITER);
    sel_init = (state_q == S_INIT);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

  assign winner_valid = winner_valid_q;
  assign winner_idx   = winner_idx_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller. A small behavioral model of the four
// neuron load registers feeds value_0..3 from bench-chosen init/update vectors.
module tb_maxnet_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] value_0, value_1, value_2, value_3;
  logic        load, sel_init, busy, done;
  logic        winner_valid;
  logic [1:0]  winner_idx;
  logic        timeout;
  logic [7:0]  iter_count;

  int tests = 0;
  int fails = 0;

  maxnet_controller #(.MAX_ITER(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .value_0      (value_0),
    .value_1      (value_1),
    .value_2      (value_2),
    .value_3      (value_3),
    .load         (load),
    .sel_init     (sel_init),
    .busy         (busy),
    .done         (done),
    .winner_valid (winner_valid),
    .winner_idx   (winner_idx),
    .timeout      (timeout),
    .iter_count   (iter_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Neuron register model: init vector on sel_init loads, then successive
  // update vectors; once updates run out the registers hold.
  logic [31:0] init_v [4];
  logic [31:0] upd    [2][4];
  int          num_upd;
  logic [31:0] nreg   [4];
  int          upd_ptr;
  int          load_cnt = 0;

  always @(posedge clock) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      if (sel_init) begin
        for (int i = 0; i < 4; i++) nreg[i] <= init_v[i];
        upd_ptr <= 0;
      end else if (upd_ptr < num_upd) begin
        for (int i = 0; i < 4; i++) nreg[i] <= upd[upd_ptr][i];
        upd_ptr <= upd_ptr + 1;
      end
    end
  end

  assign value_0 = nreg[0];
  assign value_1 = nreg[1];
  assign value_2 = nreg[2];
  assign value_3 = nreg[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"},
        {20'd0, load, sel_init, busy, done, winner_valid, winner_idx, timeout, iter_count},
        32'd0);
  endtask

  // Start one search; returns with the time at the negedge of the DONE cycle
  // (or after the cycle budget expires). lat counts cycles from the start edge.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [31:0] d,
                     input int nu, input bit pulse,
                     output int lat, output int loads);
    int l0;
    init_v[0] = a; init_v[1] = b; init_v[2] = c; init_v[3] = d;
    num_upd = nu;
    @(negedge clock);
    l0 = load_cnt;
    start = 1'b1;
    @(posedge clock);
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      start = pulse && (lat == 3 || done);
      if (done) break;
    end
    loads = load_cnt - l0;
  endtask

  int lat, loads, n;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_upd = 0;
    for (int i = 0; i < 4; i++) init_v[i] = 32'd0;
    for (int j = 0; j < 2; j++) for (int i = 0; i < 4; i++) upd[j][i] = 32'd0;

    // Reset acts without a clock edge.
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_async");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk_all_zero("idle_10cyc");

    // Single positive neuron at index 0.
    run(32'd5, 32'd0, 32'd0, 32'd0, 0, 1'b0, lat, loads);
    chk("single_lat", lat, 3);
    chk("single_wv", winner_valid, 1);
    chk("single_idx", winner_idx, 0);
    chk("single_iter", iter_count, 0);
    chk("single_to", timeout, 0);
    chk("single_loads", loads, 1);
    @(negedge clock);
    start = 1'b0;
    chk("single_done_pulse", done, 0);
    chk("single_busy_after", busy, 0);
    chk("single_wv_hold", winner_valid, 1);

    // Two iterations of inhibition before index 0 wins.
    upd[0][0] = 32'd7; upd[0][1] = 32'd2;          upd[0][2] = 0; upd[0][3] = 0;
    upd[1][0] = 32'd6; upd[1][1] = 32'hFFFF_FFFE;  upd[1][2] = 0; upd[1][3] = 0;
    run(32'd10, 32'd8, 32'd0, 32'd0, 2, 1'b0, lat, loads);
    chk("iter2_lat", lat, 7);
    chk("iter2_wv", winner_valid, 1);
    chk("iter2_idx", winner_idx, 0);
    chk("iter2_iter", iter_count, 2);
    chk("iter2_to", timeout, 0);
    chk("iter2_loads", loads, 3);
    @(negedge clock);
    start = 1'b0;

    // No positive neuron at all.
    run(32'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, 0, 1'b0, lat, loads);
    chk("none_lat", lat, 3);
    chk("none_wv", winner_valid, 0);
    chk("none_to", timeout, 0);
    chk("none_iter", iter_count, 0);
    @(negedge clock);
    start = 1'b0;

    // Winner at index 3, and at index 2 beside a sign-bit-only negative.
    run(32'd0, 32'd0, 32'd0, 32'd7, 0, 1'b0, lat, loads);
    chk("idx3_wv", winner_valid, 1);
    chk("idx3_idx", winner_idx, 3);
    @(negedge clock);
    start = 1'b0;
    run(32'h8000_0000, 32'd0, 32'd9, 32'd0, 0, 1'b0, lat, loads);
    chk("idx2_wv", winner_valid, 1);
    chk("idx2_idx", winner_idx, 2);
    @(negedge clock);
    start = 1'b0;

    // Ties never resolve: timeout at MAX_ITER=3.
    run(32'd4, 32'd4, 32'd0, 32'd0, 0, 1'b0, lat, loads);
    chk("tmo_lat", lat, 9);
    chk("tmo_to", timeout, 1);
    chk("tmo_wv", winner_valid, 0);
    chk("tmo_iter", iter_count, 3);
    @(negedge clock);
    start = 1'b0;
    chk("tmo_hold_to", timeout, 1);
    chk("tmo_hold_iter", iter_count, 3);

    // Start pulses during ITER and during DONE are ignored.
    run(32'd10, 32'd8, 32'd0, 32'd0, 2, 1'b1, lat, loads);
    chk("pulse_lat", lat, 7);
    chk("pulse_wv", winner_valid, 1);
    @(negedge clock);
    start = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clock);
      if (busy) n++;
    end
    chk("pulse_no_extra", n, 0);

    // Reset during ITER aborts immediately.
    init_v[0] = 32'd4; init_v[1] = 32'd4; init_v[2] = 0; init_v[3] = 0;
    num_upd = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(load && !sel_init) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("rst_reach_iter", {30'd0, load, sel_init}, 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_load", load, 0);
    chk("rst_mid_busy", busy, 0);
    chk_all_zero("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clock);
      if (busy) n++;
    end
    chk("rst_stays_idle", n, 0);
    chk_all_zero("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
